// File: rtl/mem_port_arbiter.sv
// One-access-per-cycle arbiter between fetch (I) and load/store (D) on a single-port memory.
// Define ARB_FAIRNESS_EN to bound fetch starvation with a wait counter.
module mem_port_arbiter #(
    parameter int AW       = 16,
    parameter int DW       = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        I_RESP,
        D_RESP
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   force_i;

`ifdef ARB_FAIRNESS_EN
    localparam int CW = $clog2(MAX_WAIT) + 1;

    logic [CW-1:0] wait_q;

    assign force_i = i_req && (wait_q >= CW'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q <= '0;
        end else if (!i_req || i_gnt) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_q + 1'b1;
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;

    assign force_i = 1'b0;
`endif

    // Grants and memory drive are forced idle while reset is held
    always_comb begin
        i_gnt     = 1'b0;
        d_gnt     = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        state_d   = IDLE;
        if (!rst) begin
            if (d_req && !force_i) begin
                d_gnt = 1'b1;
            end else if (i_req) begin
                i_gnt = 1'b1;
            end
            mem_wdata = d_wdata;
            mem_we    = d_gnt & d_we;
            if (d_gnt) begin
                mem_addr = d_addr;
                state_d  = D_RESP;
            end else if (i_gnt) begin
                mem_addr = i_addr;
                state_d  = I_RESP;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            state_q <= state_d;
            if (i_gnt) begin
                i_rdata <= mem_rdata;
            end
            if (d_gnt) begin
                d_rdata <= d_we ? '0 : mem_rdata;
            end
        end
    end

    assign i_rvalid = (state_q == I_RESP);
    assign d_rvalid = (state_q == D_RESP);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a byte-addressed memory model.
// Fairness expectations follow ARB_FAIRNESS_EN when the bench is built with it.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [15:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .DW(16), .MAX_WAIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata)
    );

    assign mem_rdata = {mem[mem_addr + 16'd1], mem[mem_addr]};

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]         <= mem_wdata[7:0];
            mem[mem_addr + 16'd1] <= mem_wdata[15:8];
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_req   = 1'b0;
        i_addr  = 16'h0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = 16'h0;
        d_wdata = 16'h0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        i_req   = 1'b1;
        i_addr  = 16'h1234;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0200;
        d_wdata = 16'hDEAD;
        @(negedge clk);
        n_checks++;
        if ({i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b want 00000",
                     {i_gnt, d_gnt, mem_we, i_rvalid, d_rvalid});
        end
        n_checks++;
        if ({mem_addr, mem_wdata, i_rdata, d_rdata} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_data got %h want 0",
                     {mem_addr, mem_wdata, i_rdata, d_rdata});
        end
        @(negedge clk);
        n_checks++;
        if ({mem[16'h0200], mem[16'h0201]} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_nowrite got %h want 0000",
                     {mem[16'h0200], mem[16'h0201]});
        end
        step();
        idle_inputs();
        rst = 1'b0;
        step();
    endtask

    task automatic test_fetch();
        i_req  = 1'b1;
        i_addr = 16'h0002;
        @(negedge clk);
        n_checks++;
        if ({i_gnt, d_gnt, i_rvalid} !== 3'b100 || mem_addr !== 16'h0002) begin
            n_fail++;
            $display("FAIL fetch_gnt got gnt=%b%b rv=%b addr=%h want 10 0 0002",
                     i_gnt, d_gnt, i_rvalid, mem_addr);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 16'h000F || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_resp got rv=%b data=%h drv=%b want 1 000f 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b0 || i_rdata !== 16'h000F) begin
            n_fail++;
            $display("FAIL fetch_after got rv=%b data=%h want 0 000f",
                     i_rvalid, i_rdata);
        end
    endtask

    task automatic test_store_load();
        step();
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'hBEEF;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, i_gnt, mem_we} !== 3'b101 || mem_addr !== 16'h0100 ||
            mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL store_gnt got gnt=%b%b we=%b addr=%h wd=%h want 10 1 0100 beef",
                     d_gnt, i_gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        d_we    = 1'b0;
        d_wdata = 16'h0;
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'h0000) begin
            n_fail++;
            $display("FAIL store_ack got rv=%b data=%h want 1 0000", d_rvalid, d_rdata);
        end
        n_checks++;
        if (d_gnt !== 1'b1 || mem_we !== 1'b0) begin
            n_fail++;
            $display("FAIL load_gnt got gnt=%b we=%b want 1 0", d_gnt, mem_we);
        end
        step();
        d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b1 || d_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL load_resp got rv=%b data=%h want 1 beef", d_rvalid, d_rdata);
        end
        step();
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL load_after got rv=%b want 0", d_rvalid);
        end
    endtask

    task automatic test_collision();
        step();
        i_req   = 1'b1;
        i_addr  = 16'h0010;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0010;
        d_wdata = 16'hA55A;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, i_gnt} !== 2'b10 || mem_we !== 1'b1) begin
            n_fail++;
            $display("FAIL coll_first got d/i=%b%b we=%b want 10 1", d_gnt, i_gnt, mem_we);
        end
        step();
        idle_inputs();
        i_req  = 1'b1;
        i_addr = 16'h0010;
        @(negedge clk);
        n_checks++;
        if ({d_gnt, i_gnt} !== 2'b01 || d_rvalid !== 1'b1 || d_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL coll_second got d/i=%b%b drv=%b dd=%h want 01 1 0000",
                     d_gnt, i_gnt, d_rvalid, d_rdata);
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 16'hA55A || d_rvalid !== 1'b0) begin
            n_fail++;
            $display("FAIL coll_fetch got rv=%b data=%h drv=%b want 1 a55a 0",
                     i_rvalid, i_rdata, d_rvalid);
        end
        step();
    endtask

    task automatic test_fairness();
        logic exp_i;
        i_req  = 1'b1;
        i_addr = 16'h0002;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0100;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
`ifdef ARB_FAIRNESS_EN
            exp_i = (c == 5) || (c == 10);
`else
            exp_i = 1'b0;
`endif
            n_checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
                n_fail++;
                $display("FAIL fair_cycle%0d got i=%b d=%b want i=%b d=%b",
                         c, i_gnt, d_gnt, exp_i, !exp_i);
            end
            step();
        end
        idle_inputs();
        step();
    endtask

    task automatic test_reset_mid();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 16'h0100;
        @(negedge clk);
        n_checks++;
        if (d_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_gnt got %b want 1", d_gnt);
        end
        step();
        rst     = 1'b1;
        d_we    = 1'b1;
        d_addr  = 16'h0300;
        d_wdata = 16'hC0DE;
        @(negedge clk);
        n_checks++;
        if (d_rvalid !== 1'b0 || d_rdata !== 16'h0 || i_rdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_drop got rv=%b dd=%h id=%h want 0 0000 0000",
                     d_rvalid, d_rdata, i_rdata);
        end
        n_checks++;
        if ({d_gnt, i_gnt, mem_we} !== 3'b0 || mem_addr !== 16'h0 ||
            mem_wdata !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_outs got gnt=%b%b we=%b addr=%h wd=%h want 0",
                     d_gnt, i_gnt, mem_we, mem_addr, mem_wdata);
        end
        step();
        idle_inputs();
        rst    = 1'b0;
        i_req  = 1'b1;
        i_addr = 16'h0002;
        @(negedge clk);
        n_checks++;
        if (i_gnt !== 1'b1 || d_rvalid !== 1'b0 ||
            {mem[16'h0300], mem[16'h0301]} !== 16'h0) begin
            n_fail++;
            $display("FAIL rstmid_resume got gnt=%b drv=%b m300=%h want 1 0 0000",
                     i_gnt, d_rvalid, {mem[16'h0301], mem[16'h0300]});
        end
        step();
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_rvalid !== 1'b1 || i_rdata !== 16'h000F) begin
            n_fail++;
            $display("FAIL rstmid_fetch got rv=%b data=%h want 1 000f", i_rvalid, i_rdata);
        end
        step();
    endtask

    task automatic test_back_to_back();
        logic is_d;
        for (int c = 0; c < 5; c++) begin
            is_d   = c[0];
            idle_inputs();
            if (c < 4) begin
                i_req  = !is_d;
                i_addr = 16'h0000;
                d_req  = is_d;
                d_addr = 16'h002C;
            end
            @(negedge clk);
            if (c < 4) begin
                n_checks++;
                if (i_gnt !== !is_d || d_gnt !== is_d ||
                    mem_addr !== (is_d ? 16'h002C : 16'h0000)) begin
                    n_fail++;
                    $display("FAIL b2b_gnt%0d got i=%b d=%b addr=%h", c, i_gnt, d_gnt, mem_addr);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (i_rvalid !== is_d || d_rvalid !== !is_d || i_rdata !== 16'h0 ||
                    (!is_d && d_rdata !== 16'h0)) begin
                    n_fail++;
                    $display("FAIL b2b_resp%0d got irv=%b drv=%b id=%h dd=%h want %b %b 0000",
                             c, i_rvalid, d_rvalid, i_rdata, d_rdata, is_d, !is_d);
                end
            end
            step();
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[16'h0002] = 8'h0F;
        idle_inputs();
        test_reset();
        test_fetch();
        test_store_load();
        test_collision();
        test_fairness();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
